// File: rtl/rx_fcs_checker_if.sv
// Byte-stream bundle for the FCS checker: received stream in (s_*) and
// FCS-stripped stream out (m_*).
interface rx_fcs_checker_if;
    logic [7:0] s_rx_data;
    logic       s_rx_valid;
    logic       s_rx_last;
    logic       s_rx_error;
    logic [7:0] m_rx_data;
    logic       m_rx_valid;
    logic       m_rx_last;

    modport master (
        output s_rx_data, s_rx_valid, s_rx_last, s_rx_error,
        input  m_rx_data, m_rx_valid, m_rx_last
    );

    modport slave (
        input  s_rx_data, s_rx_valid, s_rx_last, s_rx_error,
        output m_rx_data, m_rx_valid, m_rx_last
    );
endinterface

// File: rtl/rx_fcs_checker.sv
// Ethernet receive FCS checker: CRC-32 over every byte, strips the 4 FCS bytes
// through a delay line, and flags/counts good and bad frames.
module rx_fcs_checker #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    rx_fcs_checker_if.slave        rx,
    output logic                   o_frame_good,
    output logic                   o_frame_bad,
    output logic [COUNT_WIDTH-1:0] o_good_count,
    output logic [COUNT_WIDTH-1:0] o_bad_count
);

    localparam logic [31:0] CrcInit    = 32'hFFFF_FFFF;
    localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
    localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

    typedef enum logic [1:0] {StIdle, StFill, StPass} state_e;

    state_e                   r_state, w_state_next;
    logic [1:0]               r_fill, w_fill_next;
    logic [3:0][7:0]          r_dly;
    logic [31:0]              r_crc, w_crc_next, w_crc_seed;
    logic                     r_err, w_err_next;
    logic                     w_fcs_ok;
    logic                     w_eof;
    logic [7:0]               r_m_data, w_m_data;
    logic                     r_m_valid, w_m_valid;
    logic                     r_m_last, w_m_last;
    logic                     r_good, w_good;
    logic                     r_bad, w_bad;
    logic [COUNT_WIDTH-1:0]   r_good_cnt, w_good_cnt;
    logic [COUNT_WIDTH-1:0]   r_bad_cnt, w_bad_cnt;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v;
        v = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ CrcPoly) : (v >> 1);
        end
        return v;
    endfunction

    // Being in StIdle means the next valid byte opens a new frame.
    always_comb begin
        w_crc_seed = (r_state == StIdle) ? CrcInit : r_crc;
        w_crc_next = r_crc;
        w_err_next = r_err;
        if (rx.s_rx_valid) begin
            w_crc_next = crc_byte(w_crc_seed, rx.s_rx_data);
            w_err_next = ((r_state == StIdle) ? 1'b0 : r_err) | rx.s_rx_error;
        end
        w_fcs_ok = (w_crc_next == CrcResidue) && !w_err_next;
        w_eof    = rx.s_rx_valid && rx.s_rx_last;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_fill     <= 2'd0;
            r_dly      <= '0;
            r_crc      <= CrcInit;
            r_err      <= 1'b0;
            r_m_data   <= 8'h00;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_good     <= 1'b0;
            r_bad      <= 1'b0;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fill     <= w_fill_next;
            r_crc      <= w_crc_next;
            r_err      <= w_err_next;
            r_m_data   <= w_m_data;
            r_m_valid  <= w_m_valid;
            r_m_last   <= w_m_last;
            r_good     <= w_good;
            r_bad      <= w_bad;
            r_good_cnt <= w_good_cnt;
            r_bad_cnt  <= w_bad_cnt;
            if (rx.s_rx_valid) begin
                r_dly <= {r_dly[2:0], rx.s_rx_data};
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fill_next  = r_fill;
        if (rx.s_rx_valid) begin
            if (rx.s_rx_last) begin
                w_state_next = StIdle;
                w_fill_next  = 2'd0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        w_state_next = StFill;
                        w_fill_next  = 2'd1;
                    end
                    StFill: begin
                        if (r_fill == 2'd3) begin
                            w_state_next = StPass;
                            w_fill_next  = 2'd0;
                        end else begin
                            w_fill_next = r_fill + 2'd1;
                        end
                    end
                    StPass: w_state_next = StPass;
                    default: begin
                        w_state_next = StIdle;
                        w_fill_next  = 2'd0;
                    end
                endcase
            end
        end
    end

    // Oldest held byte leaves the delay line; in StPass on the last beat it is
    // the final non-FCS byte.
    always_comb begin
        w_m_valid  = rx.s_rx_valid && (r_state == StPass);
        w_m_data   = w_m_valid ? r_dly[3] : r_m_data;
        w_m_last   = w_m_valid && rx.s_rx_last;
        w_good     = w_eof && (r_state == StPass) && w_fcs_ok;
        w_bad      = w_eof && !((r_state == StPass) && w_fcs_ok);
        w_good_cnt = r_good_cnt;
        w_bad_cnt  = r_bad_cnt;
        if (w_good && (r_good_cnt != '1)) begin
            w_good_cnt = r_good_cnt + COUNT_WIDTH'(1);
        end
        if (w_bad && (r_bad_cnt != '1)) begin
            w_bad_cnt = r_bad_cnt + COUNT_WIDTH'(1);
        end
    end

    assign rx.m_rx_data  = r_m_data;
    assign rx.m_rx_valid = r_m_valid;
    assign rx.m_rx_last  = r_m_last;
    assign o_frame_good  = r_good;
    assign o_frame_bad   = r_bad;
    assign o_good_count  = r_good_cnt;
    assign o_bad_count   = r_bad_cnt;

endmodule
